// File: rtl/aes_vec_pkg.sv
// aes_vec_pkg: shared constants and GF(2^8) helpers for the sequential AES
// vector unit.
//   - op one-hot codes {ark,ss,ssm}
//   - FSM state type and state constants
//   - xt2 / xtN / gf_mul / gf_inv field arithmetic (poly 0x11b)
//   - mixcolumn: forward or inverse MixColumns on one column
//   - shift_src: ShiftRows source byte index within a 16-byte lane
package aes_vec_pkg;

   localparam logic [2:0] OP_ARK = 3'b100;
   localparam logic [2:0] OP_SS  = 3'b010;
   localparam logic [2:0] OP_SSM = 3'b001;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_SUB  = 2'd1;
   localparam state_t ST_DONE = 2'd2;

   function automatic logic [7:0] xt2(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // multiply by a small (4-bit) constant
   function automatic logic [7:0] xtN(input logic [7:0] b, input logic [3:0] n);
      logic [7:0] acc, p;
      acc = 8'h00;
      p   = b;
      for (int i = 0; i < 4; i++) begin
         if (n[i]) acc = acc ^ p;
         p = xt2(p);
      end
      return acc;
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
      logic [7:0] acc, p;
      acc = 8'h00;
      p   = x;
      for (int i = 0; i < 8; i++) begin
         if (y[i]) acc = acc ^ p;
         p = xt2(p);
      end
      return acc;
   endfunction

   // x^254 == x^-1 (and 0 -> 0), via repeated squaring
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] p, r;
      p = x;
      r = 8'h01;
      for (int i = 0; i < 7; i++) begin
         p = gf_mul(p, p);
         r = gf_mul(r, p);
      end
      return r;
   endfunction

   // returns {row3,row2,row1,row0}; row r = c0*b[r]^c1*b[r+1]^c2*b[r+2]^c3*b[r+3]
   function automatic logic [31:0] mixcolumn(input logic [7:0] b0, input logic [7:0] b1,
                                             input logic [7:0] b2, input logic [7:0] b3,
                                             input logic inv);
      logic [3:0][7:0] b;
      logic [3:0]      c0, c1, c2, c3;
      logic [31:0]     r;
      b  = {b3, b2, b1, b0};
      c0 = inv ? 4'he : 4'h2;
      c1 = inv ? 4'hb : 4'h3;
      c2 = inv ? 4'hd : 4'h1;
      c3 = inv ? 4'h9 : 4'h1;
      r  = '0;
      for (int i = 0; i < 4; i++)
         r[8*i +: 8] = xtN(b[2'(i)], c0) ^ xtN(b[2'(i + 1)], c1) ^
                       xtN(b[2'(i + 2)], c2) ^ xtN(b[2'(i + 3)], c3);
      return r;
   endfunction

   // p = 4*col + row; source column is col+row (fwd) or col-row (inv), mod 4
   function automatic logic [3:0] shift_src(input logic [3:0] p, input logic inv);
      logic [1:0] sc;
      sc = inv ? (p[3:2] - p[1:0]) : (p[3:2] + p[1:0]);
      return {sc, p[1:0]};
   endfunction

endpackage

// File: rtl/aes_sbox8.sv
// aes_sbox8: one-byte AES S-box, computed as field inverse + affine map.
//   din  : input byte
//   inv  : 1 selects the inverse S-box (only when AES_INV_EN is defined)
//   dout : substituted byte
// Macro AES_INV_EN: builds the inverse path; otherwise inv is ignored and
// only the forward S-box exists.
module aes_sbox8 import aes_vec_pkg::*; (
   input  logic [7:0] din,
   input  logic       inv,
   output logic [7:0] dout
);

   logic [7:0] gi;
   logic [7:0] fwd;

`ifdef AES_INV_EN
   logic [7:0] ia;
   // inverse affine first, then a single shared field inverter serves both directions
   assign ia   = {din[6:0], din[7]} ^ {din[4:0], din[7:5]} ^ {din[1:0], din[7:2]} ^ 8'h05;
   assign gi   = gf_inv(inv ? ia : din);
   assign dout = inv ? gi : fwd;
`else
   logic unused_inv;
   assign unused_inv = inv;
   assign gi         = gf_inv(din);
   assign dout       = fwd;
`endif

   assign fwd = gi ^ {gi[6:0], gi[7]} ^ {gi[5:0], gi[7:6]} ^
                {gi[4:0], gi[7:5]} ^ {gi[3:0], gi[7:4]} ^ 8'h63;

endmodule

// File: rtl/aes_vec_seq.sv
// aes_vec_seq: multi-cycle AES vector unit, VLEN/128 independent lanes,
// SBOX_PAR time-shared S-boxes.
//   clk, rst (sync, active-high)
//   in_valid/in_ready : request handshake (in_ready = idle)
//   op {ark,ss,ssm} one-hot, inv, a (ARK round-constant word), vb (source)
//   out_valid/out_ready : result handshake; vc result, err illegal-request flag
// Macro AES_INV_EN: enables inverse S-box/MixColumns; without it an SS/SSM
// request with inv=1 returns vc=0, err=1 at the normal SS latency.
module aes_vec_seq import aes_vec_pkg::*; #(
   parameter int VLEN     = 128,
   parameter int SBOX_PAR = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      op,
   input  logic            inv,
   input  logic [31:0]     a,
   input  logic [VLEN-1:0] vb,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [VLEN-1:0] vc,
   output logic            err
);

   localparam int LANES = VLEN / 128;
   localparam int NB    = 16 * LANES;
   localparam int IW    = $clog2(NB);
   localparam int CW    = $clog2(NB + 1);
   // ARK substitutes 4 bytes per lane; round up so odd lane counts still finish
   localparam int ARK_LIM = ((4 * LANES + SBOX_PAR - 1) / SBOX_PAR) * SBOX_PAR;

   state_t                state_q;
   logic [2:0]            op_q;
   logic                  inv_q;
   logic [31:0]           a_q;
   logic [NB-1:0][7:0]    src_q;
   logic [NB-1:0][7:0]    st_q;
   logic [CW-1:0]         cnt_q;

   logic                  is_ark, is_ss, is_ssm, illegal, bad, sub_inv, mc_inv;
   logic [CW-1:0]         lim;
   logic [SBOX_PAR-1:0][7:0] sb_out;
   logic [NB-1:0][7:0]    res;

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);

   always_comb begin
      is_ark  = (op_q == OP_ARK);
      is_ss   = (op_q == OP_SS);
      is_ssm  = (op_q == OP_SSM);
      illegal = !(is_ark || is_ss || is_ssm);
`ifdef AES_INV_EN
      bad     = illegal;
      mc_inv  = inv_q;
`else
      bad     = illegal || ((is_ss || is_ssm) && inv_q);
      mc_inv  = 1'b0;
`endif
      sub_inv = inv_q && !is_ark;
      // byte count to process before the result is latched
      lim     = illegal ? CW'(SBOX_PAR) : (is_ark ? CW'(ARK_LIM) : CW'(NB));
   end

   // slot k substitutes destination byte cnt+k; the source byte is picked
   // through the ShiftRows permutation (SS/SSM) or RotWord of w3 (ARK)
   for (genvar k = 0; k < SBOX_PAR; k++) begin : g_sbox
      logic [7:0]    din;
      logic [IW-1:0] si;
      int            j;
      always_comb begin
         j = int'(cnt_q) + k;
         if (is_ark)
            si = IW'((j / 4) * 16 + 12 + ((j + 1) % 4));
         else
            si = IW'((j / 16) * 16 + int'(shift_src(4'(j % 16), inv_q)));
         din = (j < (is_ark ? 4 * LANES : NB)) ? src_q[si] : 8'h00;
      end
      aes_sbox8 u_sbox (.din(din), .inv(sub_inv), .dout(sb_out[k]));
   end

   // final combine from the fully substituted state
   always_comb begin
      logic [31:0] t;
      logic [31:0] col;
      t   = '0;
      col = '0;
      res = '0;
      if (!bad) begin
         if (is_ark) begin
            for (int l = 0; l < LANES; l++) begin
               t = st_q[4*l +: 4] ^ a_q;
               for (int w = 0; w < 4; w++) begin
                  t = t ^ src_q[16*l + 4*w +: 4];
                  res[16*l + 4*w +: 4] = t;
               end
            end
         end else if (is_ss) begin
            res = st_q;
         end else begin
            for (int c = 0; c < 4 * LANES; c++) begin
               col = st_q[4*c +: 4];
               res[4*c +: 4] = mixcolumn(col[7:0], col[15:8], col[23:16], col[31:24], mc_inv);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         op_q    <= '0;
         inv_q   <= 1'b0;
         a_q     <= '0;
         src_q   <= '0;
         st_q    <= '0;
         cnt_q   <= '0;
         vc      <= '0;
         err     <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  op_q    <= op;
                  inv_q   <= inv;
                  a_q     <= a;
                  src_q   <= vb;
                  cnt_q   <= '0;
                  state_q <= ST_SUB;
               end
            end
            ST_SUB: begin
               if (cnt_q == lim) begin
                  vc      <= res;
                  err     <= bad;
                  state_q <= ST_DONE;
               end else begin
                  for (int k = 0; k < SBOX_PAR; k++)
                     if (int'(cnt_q) + k < NB)
                        st_q[IW'(int'(cnt_q) + k)] <= sb_out[k];
                  cnt_q <= cnt_q + CW'(SBOX_PAR);
               end
            end
            ST_DONE: begin
               if (out_ready) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_vec_seq.sv
// tb_aes_vec_seq: two instances driven in lockstep -- VLEN=128/SBOX_PAR=4 and
// VLEN=512/SBOX_PAR=16 (both have SS/SSM latency 5, ARK 2). Results are
// compared against a byte-level AES reference model with its own S-box
// tables built by brute-force field inversion.
module tb_aes_vec_seq;

   localparam logic [2:0] ARK = 3'b100;
   localparam logic [2:0] SS  = 3'b010;
   localparam logic [2:0] SSM = 3'b001;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         inv = 1'b0;
   logic         out_ready = 1'b0;
   logic [2:0]   op = '0;
   logic [31:0]  a = '0;
   logic [511:0] vb = '0;
   logic         in_ready0, in_ready1, out_valid0, out_valid1, err0, err1;
   logic [127:0] vc0;
   logic [511:0] vc1;

   logic [7:0]   sbt  [256];
   logic [7:0]   isbt [256];
   int           n_chk = 0;
   int           n_err = 0;

   always #5 clk = ~clk;

   aes_vec_seq #(.VLEN(128), .SBOX_PAR(4)) u_dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
      .op(op), .inv(inv), .a(a), .vb(vb[127:0]),
      .out_valid(out_valid0), .out_ready(out_ready), .vc(vc0), .err(err0));

   aes_vec_seq #(.VLEN(512), .SBOX_PAR(16)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
      .op(op), .inv(inv), .a(a), .vb(vb),
      .out_valid(out_valid1), .out_ready(out_ready), .vc(vc1), .err(err1));

   task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
      logic [7:0] p, xx;
      p  = 8'h00;
      xx = x;
      for (int i = 0; i < 8; i++) begin
         if (y[i]) p = p ^ xx;
         xx = {xx[6:0], 1'b0} ^ (xx[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   task automatic build_tables();
      logic [7:0] iv8, s, c63;
      c63 = 8'h63;
      for (int x = 0; x < 256; x++) begin
         iv8 = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) iv8 = 8'(y);
         for (int i = 0; i < 8; i++)
            s[i] = iv8[i] ^ iv8[(i+4)%8] ^ iv8[(i+5)%8] ^ iv8[(i+6)%8] ^ iv8[(i+7)%8] ^ c63[i];
         sbt[x]  = s;
         isbt[s] = 8'(x);
      end
   endtask

   // {err, vc} for a 512-bit (4-lane) request; lane 0 also serves the 128-bit DUT
   function automatic logic [512:0] ref_model(input logic [2:0] o, input logic iv,
                                              input logic [31:0] ak, input logic [511:0] v);
      logic [7:0]   ib [64];
      logic [7:0]   sr [64];
      logic [3:0]   cf [4];
      logic [31:0]  w  [4];
      logic [31:0]  t;
      logic [7:0]   acc;
      logic [511:0] r;
      int           sc;
      bit           bad;
      r = '0;
      for (int i = 0; i < 64; i++) ib[i] = v[8*i +: 8];
      bad = ($countones(o) != 1);
`ifndef AES_INV_EN
      if (iv && o != ARK) bad = 1'b1;
`endif
      if (bad) return {1'b1, 512'b0};
      if (o == ARK) begin
         for (int l = 0; l < 4; l++) begin
            for (int i = 0; i < 4; i++) w[i] = v[128*l + 32*i +: 32];
            t = {w[3][7:0], w[3][31:8]};
            t = {sbt[t[31:24]], sbt[t[23:16]], sbt[t[15:8]], sbt[t[7:0]]} ^ ak;
            for (int i = 0; i < 4; i++) begin
               t = t ^ w[i];
               r[128*l + 32*i +: 32] = t;
            end
         end
         return {1'b0, r};
      end
      for (int l = 0; l < 4; l++)
         for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++) begin
               sc = iv ? (c - rr + 4) % 4 : (c + rr) % 4;
               sr[16*l + 4*c + rr] = iv ? isbt[ib[16*l + 4*sc + rr]] : sbt[ib[16*l + 4*sc + rr]];
            end
      if (o == SS) begin
         for (int i = 0; i < 64; i++) r[8*i +: 8] = sr[i];
         return {1'b0, r};
      end
      if (iv) begin cf[0] = 4'he; cf[1] = 4'hb; cf[2] = 4'hd; cf[3] = 4'h9; end
      else    begin cf[0] = 4'h2; cf[1] = 4'h3; cf[2] = 4'h1; cf[3] = 4'h1; end
      for (int k = 0; k < 16; k++)
         for (int rr = 0; rr < 4; rr++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) acc = acc ^ gmul({4'h0, cf[j]}, sr[4*k + (rr+j)%4]);
            r[32*k + 8*rr +: 8] = acc;
         end
      return {1'b0, r};
   endfunction

   function automatic logic [511:0] rand512();
      logic [511:0] v;
      for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom;
      return v;
   endfunction

   // one full request/response; inputs change #1 after a rising edge
   task automatic xact(input logic [2:0] o, input logic iv, input logic [31:0] ak,
                       input logic [511:0] v, input int hold, output logic [127:0] got0);
      logic [512:0] m;
      int           n, lat;
      got0 = '0;
      m    = ref_model(o, iv, ak, v);
      lat  = ($countones(o) == 1 && o == ARK) ? 2 : ($countones(o) == 1 ? 5 : 2);
      op = o; inv = iv; a = ak; vb = v; in_valid = 1'b1;
      chk("in_ready0_idle", in_ready0, 1'b1);
      chk("in_ready1_idle", in_ready1, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 0;
      while (!out_valid0 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      if (!out_valid0) begin
         chk("out_valid_timeout", 1'b0, 1'b1);
         return;
      end
      got0 = vc0;
      chk("latency", n, lat);
      chk("out_valid1", out_valid1, 1'b1);
      chk("vc0", vc0, m[127:0]);
      chk("vc1", vc1, m[511:0]);
      chk("err0", err0, m[512]);
      chk("err1", err1, m[512]);
      if (hold > 0) begin
         // a competing request while busy must be ignored
         vb = rand512(); op = SS; in_valid = 1'b1;
         repeat (hold) begin @(posedge clk); #1; end
         in_valid = 1'b0;
         chk("hold_vc0", vc0, m[127:0]);
         chk("hold_vc1", vc1, m[511:0]);
         chk("hold_ov0", out_valid0, 1'b1);
         chk("hold_ir0", in_ready0, 1'b0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("release_ir0", in_ready0, 1'b1);
      chk("release_ov1", out_valid1, 1'b0);
   endtask

   initial begin
      logic [127:0] g, e128;
      logic [511:0] v;
      logic [7:0]   kb [16];
      logic [7:0]   eb [16];
      logic [2:0]   o;

      build_tables();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_ir0", in_ready0, 1'b1);
      chk("rst_ir1", in_ready1, 1'b1);
      chk("rst_ov0", out_valid0, 1'b0);
      chk("rst_vc1", vc1, '0);
      chk("rst_err0", err0, 1'b0);

      xact(SS, 1'b0, 32'h0, '0, 0, g);
      chk("ss_zero", g, {16{8'h63}});
      xact(SSM, 1'b0, 32'h0, '0, 0, g);
      chk("ssm_zero", g, {16{8'h63}});
      // inverse of 0x63 is 0 when enabled; disabled build also yields 0 (err=1)
      xact(SS, 1'b1, 32'h0, {64{8'h63}}, 0, g);
      chk("ss_inv_63", g, '0);

      kb = '{8'h2b, 8'h7e, 8'h15, 8'h16, 8'h28, 8'hae, 8'hd2, 8'ha6,
             8'hab, 8'hf7, 8'h15, 8'h88, 8'h09, 8'hcf, 8'h4f, 8'h3c};
      eb = '{8'ha0, 8'hfa, 8'hfe, 8'h17, 8'h88, 8'h54, 8'h2c, 8'hb1,
             8'h23, 8'ha3, 8'h39, 8'h39, 8'h2a, 8'h6c, 8'h76, 8'h05};
      v = rand512();
      for (int i = 0; i < 16; i++) begin
         v[8*i +: 8]    = kb[i];
         e128[8*i +: 8] = eb[i];
      end
      xact(ARK, 1'b0, 32'h1, v, 0, g);
      chk("ark_fips", g, e128);

      xact(3'b110, 1'b0, $urandom, rand512(), 0, g);
      chk("illegal_vc", g, '0);

      xact(SSM, 1'b0, $urandom, rand512(), 10, g);

      repeat (24) begin
         case ($urandom_range(0, 3))
            0:       o = ARK;
            1:       o = SS;
            2:       o = SSM;
            default: o = 3'($urandom_range(0, 7));
         endcase
         xact(o, 1'($urandom_range(0, 1)), $urandom, rand512(), 0, g);
      end

      // reset in the middle of SUB discards the pending result
      op = SSM; inv = 1'b0; vb = rand512(); in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrst_ov0", out_valid0, 1'b0);
      chk("midrst_ir0", in_ready0, 1'b1);
      chk("midrst_vc0", vc0, '0);
      chk("midrst_ov1", out_valid1, 1'b0);
      chk("midrst_vc1", vc1, '0);
      repeat (3) @(posedge clk);
      #1;
      chk("midrst_stay_ov0", out_valid0, 1'b0);
      xact(SS, 1'b0, 32'h0, rand512(), 0, g);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
